// File: rtl/seq_datapath.sv
// Self-sequencing register-file/shifter/ALU datapath executing one ALU or load command per handshake.
// Define SEQ_DP_DUAL_READ_EN to fetch both ALU operands in a single read cycle.
module seq_datapath #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int RW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             kind,
  input  logic [1:0]       alu_op,
  input  logic [1:0]       shift,
  input  logic [RW-1:0]    rn,
  input  logic [RW-1:0]    rm,
  input  logic [RW-1:0]    rd,
  input  logic             a_zero,
  input  logic             use_imm,
  input  logic             wb_en,
  input  logic             load_flags,
  input  logic [1:0]       wsrc,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] ext_in,
  input  logic [WIDTH-1:0] mdata,
  input  logic [WIDTH-1:0] pc,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             n_out,
  output logic             v_out,
  output logic             z_out
);

  typedef enum logic [2:0] {IDLE, RDA, RDB, EXEC, WB, LD} state_t;
  state_t state;

  logic [1:0]              op_p0, shift_p0;
  logic [RW-1:0]           rn_p0, rm_p0, rd_p0;
  logic                    az_p0, imm_sel_p0, wb_p0, lf_p0;
  logic signed [WIDTH-1:0] imm_p0, ld_p0;
  logic signed [WIDTH-1:0] regs [NREG];
  logic signed [WIDTH-1:0] a_p1, b_p1, c_p2;
  logic                    n_p2, v_p2, z_p2;
  logic signed [WIDTH-1:0] ain, bin, alu_r;
  logic                    alu_v, accept;

  function automatic logic signed [WIDTH-1:0] shift_b(input logic signed [WIDTH-1:0] x,
                                                      input logic [1:0] sh);
    case (sh)
      2'b01:   return x <<< 1;
      2'b10:   return x >> 1;
      2'b11:   return x >>> 1;
      default: return x;
    endcase
  endfunction

  // Returns {overflow, result}; overflow only meaningful for add/sub.
  function automatic logic [WIDTH:0] alu(input logic [1:0] op,
                                         input logic signed [WIDTH-1:0] a,
                                         input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] r;
    logic ov;
    r  = '0;
    ov = 1'b0;
    case (op)
      2'b00: begin
        r  = a + b;
        ov = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      2'b01: begin
        r  = a - b;
        ov = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      2'b10:   r = a & b;
      default: r = ~b;
    endcase
    return {ov, r};
  endfunction

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign result    = c_p2;
  assign n_out     = n_p2;
  assign v_out     = v_p2;
  assign z_out     = z_p2;

  always_comb begin
    ain            = az_p0 ? '0 : a_p1;
    bin            = imm_sel_p0 ? imm_p0 : shift_b(b_p1, shift_p0);
    {alu_v, alu_r} = alu(op_p0, ain, bin);
  end

  // Stage p0: command capture; the load source is resolved here so only one word is kept.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0      <= alu_op;
      shift_p0   <= shift;
      rn_p0      <= rn;
      rm_p0      <= rm;
      rd_p0      <= rd;
      az_p0      <= a_zero;
      imm_sel_p0 <= use_imm;
      wb_p0      <= wb_en;
      lf_p0      <= load_flags;
      imm_p0     <= imm;
      case (wsrc)
        2'b00:   ld_p0 <= ext_in;
        2'b01:   ld_p0 <= imm;
        2'b10:   ld_p0 <= mdata;
        default: ld_p0 <= pc;
      endcase
    end
  end

  // Stages p1/p2: operand read, execute and writeback sequenced by the state machine.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
      a_p1  <= '0;
      b_p1  <= '0;
      c_p2  <= '0;
      n_p2  <= 1'b0;
      v_p2  <= 1'b0;
      z_p2  <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            state <= kind ? LD : RDA;
            done  <= kind;
          end
        end
        RDA: begin
          a_p1 <= regs[rn_p0];
`ifdef SEQ_DP_DUAL_READ_EN
          b_p1  <= regs[rm_p0];
          state <= EXEC;
`else
          state <= RDB;
`endif
        end
        RDB: begin
          b_p1  <= regs[rm_p0];
          state <= EXEC;
        end
        EXEC: begin
          c_p2 <= alu_r;
          if (lf_p0) begin
            n_p2 <= alu_r[WIDTH-1];
            v_p2 <= alu_v;
            z_p2 <= (alu_r == '0);
          end
          done  <= 1'b1;
          state <= WB;
        end
        WB: begin
          if (wb_p0) regs[rd_p0] <= c_p2;
          state <= IDLE;
        end
        LD: begin
          regs[rd_p0] <= ld_p0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_datapath.md
# seq_datapath

Parametrised, self-sequencing successor to the Simple RISC Machine datapath: register file, A/B/C pipeline registers, shifter, ALU and NVZ status register, driven by an internal state machine instead of per-cycle external load strobes. A controller issues one whole command (ALU operation or register load) through a valid/ready handshake. The block reads operands, executes, optionally writes back, and pulses `done`. It sits between the instruction decoder/FSM controller and memory/PC logic. It adds configurable width, register count and an optional dual-read fast path.

## Interface
Parameters:
- `WIDTH`, 16, datapath and register width (≥ 4)
- `NREG`, 8, register count (power of two, ≥ 2)
- `RW`, $clog2(NREG), register index width (derived, not overridden)

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  command present
- `req_ready`  out  1  block can accept a command
- `kind`  in  1  0 = ALU command, 1 = load-register command
- `alu_op`  in  2  00 add, 01 sub, 10 and, 11 not-B
- `shift`  in  2  applied to B: 00 none, 01 lsl 1, 10 lsr 1 (zero fill), 11 asr 1
- `rn`, `rm`, `rd`  in  RW each  A source, B source, destination
- `a_zero`  in  1  ALU A input forced to 0
- `use_imm`  in  1  ALU B input = `imm` (unshifted) instead of shifted B
- `wb_en`  in  1  ALU result written to `rd`
- `load_flags`  in  1  NVZ updated by this ALU command
- `wsrc`  in  2  load-command source: 00 `ext_in`, 01 `imm`, 10 `mdata`, 11 `pc`
- `imm`, `ext_in`, `mdata`, `pc`  in  WIDTH each  data sources, sampled at accept
- `done`  out  1  one-cycle completion pulse
- `result`  out  WIDTH  C register
- `n_out`, `v_out`, `z_out`  out  1 each  status register

## Operation
- Accept = `req_valid && req_ready` at a rising edge. All command fields and data inputs are captured into a command register at accept. Inputs are ignored otherwise.
- `req_ready` = (state == IDLE) and not `reset`.
- States: IDLE, RDA, RDB, EXEC, WB, LD.
  - IDLE: on accept, go to RDA if `kind`=0, else LD.
  - RDA: A ← R[rn]; go to RDB.
  - RDB: B ← R[rm]; go to EXEC.
  - EXEC: C ← ALU(Ain, Bin). If `load_flags`, NVZ ← flags. Go to WB.
  - WB: `done`=1. If `wb_en`, R[rd] ← C at the exiting edge. Go to IDLE.
  - LD: R[rd] ← selected source; `done`=1. Go to IDLE. A, B, C and NVZ are unchanged.
- ALU inputs: Ain = `a_zero` ? 0 : A; Bin = `use_imm` ? imm : shift(B).
- Arithmetic is modulo 2^WIDTH and two's complement.
- Flags:
  - Z = (result == 0).
  - N = result[WIDTH-1].
  - V = signed overflow for add/sub; V = 0 for and/not.
- `rn == rm` and `rd == rn` are legal. Operands are read before writeback, so R[rd] ← op(R[rd]) works.
- Back-to-back commands: a command accepted after WB sees the prior write.
- Reset (async): all registers, A, B, C and NVZ clear to 0; state goes to IDLE; `done`=0; `result`=0. Reset mid-command aborts it with no writeback.

## Timing
- ALU command: accept at edge E0. States RDA, RDB, EXEC and WB follow E0, E1, E2 and E3. `done` and the final `result` are visible in the WB cycle. The register write commits at E4. `req_ready` reasserts after E4. Throughput is one ALU command per 5 cycles.
- Load command: accept at E0; LD cycle follows; `done` high in that cycle; write at E1; `req_ready` after E1.
- `result` and NVZ hold their values until the next EXEC.

## Configuration
- `SEQ_DP_DUAL_READ_EN` defined:
  - The register file has two read ports.
  - RDA loads both A ← R[rn] and B ← R[rm], then goes directly to EXEC. RDB is unused.
  - ALU latency: `done` is visible in the cycle after E2; write at E3.
- Undefined: single read port and the full RDA→RDB sequence above.
- All other behaviour is identical with or without the macro.

## Test plan
- Reset while in EXEC → next cycle all outputs 0, `req_ready`=1, R[rd] unchanged; a following read of every register returns 0.
- Load R0←imm 0x0007, then R1←imm 0x0002. ALU add R2=R0+(R1 lsl 1) with `wb_en`, `load_flags` → `result`=0x000B, NZV=000 in the WB cycle; `done` pulses exactly once.
- Sub R3=R0−`imm` 7 (`use_imm`) with flags → `result`=0, Z=1; with `load_flags`=0 the NVZ value is held.
- WIDTH=16: 0x7FFF+0x0001 → `result`=0x8000, N=1, V=1; `and` of 0xFFFF,0x8000 → V=0, N=1.
- `req_valid` held high continuously → accepts only when `req_ready`. Cycle-accurate latency check: 5 cycles per ALU command (4 with `SEQ_DP_DUAL_READ_EN`), 2 per load; each command reads the preceding write.
- `a_zero` with `alu_op` not and `shift` asr on B=0x8004 → `result`=0x3FFD.
